// File: rtl/ifetch_cached_bp.sv
// ifetch_cached_bp
//   Instruction-fetch stage with three parts:
//     - a direct-mapped I-cache with parameterised sets and line size
//     - a 2-bit saturating branch history table
//     - a two-state miss FSM that can be redirected while a refill is outstanding
//   The stage issues at most one instruction per cycle to decode.
//
//   Ports
//     clk, rst (async, active-low), rdy (global enable; 0 freezes all state)
//     inst/inst_rdy/out_pc/is_jump           : issued instruction to decode
//     missing_pc/missing_config              : line refill request to mem-ctrl
//     return_row/return_config               : refill line from mem-ctrl
//     rollback_pc/rollback_config            : redirect from the ROB
//     update_pc/update_jump/update_config    : resolved branch outcome
//     rob_is_full/lsb_is_full/rs_is_full     : back-pressure; any high stalls issue
//
//   Optional feature: define IFETCH_GSHARE_EN to XOR a global history register
//   into the BHT index (gshare). Without it the table is plain PC-indexed bimodal.
module ifetch_cached_bp #(
    parameter int          SETS        = 16,
    parameter int          LINE_WORDS  = 16,
    parameter int          BHT_ENTRIES = 1024,
    parameter int          GHR_BITS    = 8,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    output logic [31:0]             inst,
    output logic                    inst_rdy,
    output logic [31:0]             out_pc,
    output logic                    is_jump,
    output logic [31:0]             missing_pc,
    output logic                    missing_config,
    input  logic [32*LINE_WORDS-1:0] return_row,
    input  logic                    return_config,
    input  logic [31:0]             rollback_pc,
    input  logic                    rollback_config,
    input  logic [31:0]             update_pc,
    input  logic                    update_jump,
    input  logic                    update_config,
    input  logic                    rob_is_full,
    input  logic                    lsb_is_full,
    input  logic                    rs_is_full
);
    localparam int IW  = $clog2(SETS);
    localparam int OW  = $clog2(LINE_WORDS);
    localparam int OFF = 2 + OW;
    localparam int TW  = 32 - OFF - IW;
    localparam int BW  = $clog2(BHT_ENTRIES);

    typedef enum logic {IDLE, MISS} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             pc;
    logic [SETS-1:0]         valid;
    logic [TW-1:0]           tag_q  [SETS];
    logic [32*LINE_WORDS-1:0] data_q [SETS];
    logic [1:0]              bht    [BHT_ENTRIES];
    logic [IW-1:0]           miss_idx;
    logic [TW-1:0]           miss_tag;

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [OW-1:0] wsel;
    logic          hit, stall, issue, start_miss, refill;
    logic [31:0]   word, j_imm, b_imm, pred_pc;
    logic          pred;
    logic [BW-1:0] pidx, uidx;

    assign idx  = pc[OFF +: IW];
    assign tag  = pc[31 -: TW];
    assign wsel = pc[2 +: OW];
    // Valid/tag are registered, so a line refilled this cycle only hits next cycle.
    assign hit  = valid[idx] && (tag_q[idx] == tag);
    assign word = data_q[idx][{wsel, 5'b0} +: 32];

    assign stall = rob_is_full | lsb_is_full | rs_is_full;
    // Issue only from IDLE: a PC redirected during MISS is re-checked once back in IDLE.
    assign issue = (state_q == IDLE) && hit && !stall && !rollback_config;

    assign j_imm = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
    assign b_imm = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};

`ifdef IFETCH_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;
    assign pidx = pc[2 +: BW] ^ BW'(ghr);
    assign uidx = update_pc[2 +: BW] ^ BW'(ghr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      ghr <= '0;
        else if (rdy && update_config) ghr <= {ghr[GHR_BITS-2:0], update_jump};
    end
`else
    logic unused_cfg;
    assign pidx       = pc[2 +: BW];
    assign uidx       = update_pc[2 +: BW];
    assign unused_cfg = 1'(GHR_BITS);
`endif

    logic unused_bits;
    assign unused_bits = ^{update_pc[31:2+BW], update_pc[1:0]};

    // Prediction reads the table before any same-cycle update lands.
    always_comb begin
        pred    = 1'b0;
        pred_pc = pc + 32'd4;
        case (word[6:0])
            7'b1101111: begin pred = 1'b1; pred_pc = pc + j_imm; end
            7'b1100011: if (bht[pidx][1]) begin pred = 1'b1; pred_pc = pc + b_imm; end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        start_miss = 1'b0;
        refill     = 1'b0;
        case (state_q)
            IDLE: if (!hit) begin state_d = MISS; start_miss = 1'b1; end
            MISS: if (return_config) begin state_d = IDLE; refill = 1'b1; end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            pc             <= RESET_PC;
            valid          <= '0;
            miss_idx       <= '0;
            miss_tag       <= '0;
            inst           <= '0;
            inst_rdy       <= 1'b0;
            out_pc         <= '0;
            is_jump        <= 1'b0;
            missing_pc     <= '0;
            missing_config <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            if (start_miss) begin
                miss_idx       <= idx;
                miss_tag       <= tag;
                missing_pc     <= {pc[31:OFF], {OFF{1'b0}}};
                missing_config <= 1'b1;
            end
            // Refill installs the latched line, independent of where PC is now.
            if (refill) begin
                valid[miss_idx] <= 1'b1;
                missing_pc      <= '0;
                missing_config  <= 1'b0;
            end
            if (rollback_config) begin
                pc       <= rollback_pc;
                inst_rdy <= 1'b0;
            end else if (issue) begin
                pc       <= pred_pc;
                inst_rdy <= 1'b1;
                inst     <= word;
                out_pc   <= pc;
                is_jump  <= pred;
            end else begin
                inst_rdy <= 1'b0;
            end
        end
    end

    // Line storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (rdy && refill) begin
            data_q[miss_idx] <= return_row;
            tag_q[miss_idx]  <= miss_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (rdy && update_config) begin
            if (update_jump) begin
                if (bht[uidx] != 2'b11) bht[uidx] <= bht[uidx] + 2'b01;
            end else begin
                if (bht[uidx] != 2'b00) bht[uidx] <= bht[uidx] - 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_cached_bp.sv
// Randomised bench for ifetch_cached_bp. Instruction memory is a hash of the
// address; the reference model tracks cached line addresses, the BHT and the
// outstanding refill, and knows each branch offset directly from the generator.
module tb_ifetch_cached_bp;
    localparam int SETS = 4;
    localparam int LW   = 4;
    localparam int BHT  = 64;
    localparam int OFF  = 4;

    logic            clk = 0, rst = 0, rdy = 0;
    logic [31:0]     inst, out_pc, missing_pc;
    logic            inst_rdy, is_jump, missing_config;
    logic [32*LW-1:0] return_row = '0;
    logic            return_config = 0;
    logic [31:0]     rollback_pc = 0, update_pc = 0;
    logic            rollback_config = 0, update_jump = 0, update_config = 0;
    logic            rob_is_full = 0, lsb_is_full = 0, rs_is_full = 0;

    ifetch_cached_bp #(.SETS(SETS), .LINE_WORDS(LW), .BHT_ENTRIES(BHT),
                       .GHR_BITS(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .inst(inst), .inst_rdy(inst_rdy),
        .out_pc(out_pc), .is_jump(is_jump), .missing_pc(missing_pc),
        .missing_config(missing_config), .return_row(return_row),
        .return_config(return_config), .rollback_pc(rollback_pc),
        .rollback_config(rollback_config), .update_pc(update_pc),
        .update_jump(update_jump), .update_config(update_config),
        .rob_is_full(rob_is_full), .lsb_is_full(lsb_is_full), .rs_is_full(rs_is_full));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Kinds: 0-3 ADDI, 4-5 BEQ, 6 JAL, 7 JALR
    function automatic int mem_kind(input logic [31:0] a);
        logic [31:0] h = a * 32'h9E3779B1;
        return int'(h[30:28]);
    endfunction

    function automatic int mem_imm(input logic [31:0] a);
        logic [31:0] h = a * 32'h9E3779B1;
        return (int'(h[25:20]) - 32) * 4;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h = a * 32'h9E3779B1;
        logic [31:0] im = 32'(mem_imm(a));
        int k = mem_kind(a);
        if (k == 6) return {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'b1101111};
        if (k == 4 || k == 5)
            return {im[12], im[10:5], 5'd2, 5'd1, 3'b000, im[4:1], im[11], 7'b1100011};
        if (k == 7) return {12'h0, 5'd1, 3'b000, 5'd0, 7'b1100111};
        return {h[24:0], 7'b0010011};
    endfunction

    logic [31:0] m_pc, m_inst, m_out_pc, m_missing_pc, m_miss_line;
    logic        m_rdy_o, m_jump, m_cfg, m_miss;
    bit          m_valid [SETS];
    logic [31:0] m_line  [SETS];
    logic [1:0]  m_bht   [BHT];

    task automatic model_reset();
        m_pc = 0; m_inst = 0; m_out_pc = 0; m_missing_pc = 0; m_miss_line = 0;
        m_rdy_o = 0; m_jump = 0; m_cfg = 0; m_miss = 0;
        for (int i = 0; i < SETS; i++) begin m_valid[i] = 0; m_line[i] = 0; end
        for (int i = 0; i < BHT; i++) m_bht[i] = 2'b01;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [31:0] line, tgt, old_pc;
        logic hit, take, old_miss;
        int k, s, u;
        if (!rdy) return;
        old_pc = m_pc; old_miss = m_miss;
        line = old_pc >> OFF;
        s    = int'(line % SETS);
        hit  = m_valid[s] && (m_line[s] == line);
        k    = mem_kind(old_pc);
        take = 0; tgt = old_pc + 4;
        if (k == 6) begin take = 1; tgt = old_pc + 32'(mem_imm(old_pc)); end
        else if ((k == 4 || k == 5) && m_bht[(old_pc >> 2) % BHT] >= 2) begin
            take = 1; tgt = old_pc + 32'(mem_imm(old_pc));
        end
        if (rollback_config) begin
            m_pc = rollback_pc; m_rdy_o = 0;
        end else if (!old_miss && hit && !(rob_is_full | lsb_is_full | rs_is_full)) begin
            m_rdy_o = 1; m_inst = mem_word(old_pc); m_out_pc = old_pc; m_jump = take; m_pc = tgt;
        end else m_rdy_o = 0;
        if (!old_miss) begin
            if (!hit) begin m_miss = 1; m_miss_line = line; m_missing_pc = line << OFF; m_cfg = 1; end
        end else if (return_config) begin
            m_valid[m_miss_line % SETS] = 1; m_line[m_miss_line % SETS] = m_miss_line;
            m_miss = 0; m_cfg = 0; m_missing_pc = 0;
        end
        if (update_config) begin
            u = int'((update_pc >> 2) % BHT);
            if (update_jump && m_bht[u] != 3) m_bht[u] = m_bht[u] + 1;
            if (!update_jump && m_bht[u] != 0) m_bht[u] = m_bht[u] - 1;
        end
    endtask

    task automatic check_all();
        chk("inst_rdy", 32'(inst_rdy), 32'(m_rdy_o));
        chk("inst", inst, m_inst);
        chk("out_pc", out_pc, m_out_pc);
        chk("is_jump", 32'(is_jump), 32'(m_jump));
        chk("missing_pc", missing_pc, m_missing_pc);
        chk("missing_config", 32'(missing_config), 32'(m_cfg));
    endtask

    task automatic drive_inputs(inout int burst);
        rdy = ($urandom % 10) != 0;
        if (burst == 0 && ($urandom % 100) == 0) burst = 5;
        if (burst > 0) begin
            rob_is_full = 1; lsb_is_full = 1; rs_is_full = 1; burst--;
        end else begin
            rob_is_full = ($urandom % 10) == 0;
            lsb_is_full = ($urandom % 10) == 0;
            rs_is_full  = ($urandom % 10) == 0;
        end
        rollback_config = ($urandom % 16) == 0;
        rollback_pc     = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        update_config   = ($urandom % 4) == 0;
        update_jump     = ($urandom % 3) != 0;
        update_pc       = ($urandom % 2) ? m_pc : {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        return_config   = m_miss ? (($urandom % 3) == 0) : (($urandom % 20) == 0);
        for (int w = 0; w < LW; w++)
            return_row[32*w +: 32] = m_miss ? mem_word(m_missing_pc + 32'(4*w)) : $urandom;
    endtask

    initial begin
        int  burst = 0;
        bit  did_rst = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1;
        for (int n = 0; n < 4000; n++) begin
            drive_inputs(burst);
            model_step();
            @(negedge clk);
            check_all();
            if (!did_rst && n >= 2000 && m_miss) begin
                did_rst = 1;
                #2 rst = 0;
                #1;
                chk("async_rst_missing_config", 32'(missing_config), 32'd0);
                chk("async_rst_missing_pc", missing_pc, 32'd0);
                chk("async_rst_inst_rdy", 32'(inst_rdy), 32'd0);
                chk("async_rst_out_pc", out_pc, 32'd0);
                model_reset();
                @(negedge clk);
                check_all();
                rst = 1;
            end
        end
        if (!did_rst) chk("mid_miss_reset_reached", 32'd0, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
